// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types, forward-select encodings and helpers for the hazard controller
//
// Purpose : common definitions imported by the hazard controller files.
// Contents: FWD_* forward-select encodings (also used by the EX datapath muxes),
//           register-index type, EX shadow-stage struct, forward-select helper.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rs;
    reg_idx_t rt;
    reg_idx_t dst;
    logic     wr;
    logic     load;
    logic     md;
    logic     md_div;
  } ex_stage_t;

  // A source of $0 never matches, so a destination of 0 can never forward.
  // Loads in MEM have no data yet, so they only forward once they reach WB.
  function automatic logic [1:0] fwd_sel(input reg_idx_t src,
                                         input reg_idx_t mem_dst,
                                         input logic     mem_wr,
                                         input logic     mem_load,
                                         input reg_idx_t wb_dst,
                                         input logic     wb_wr);
    logic [1:0] sel;
    sel = FWD_REG;
    if (src != 5'd0) begin
      if (mem_wr && !mem_load && (mem_dst == src)) begin
        sel = FWD_MEM;
      end else if (wb_wr && (wb_dst == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage decode fields in, stall/forward/mult-div controls out
//
// Purpose : bundles the decoded ID instruction and the hazard controls.
// Signals : id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_wr, id_load,
//           id_md, id_md_div, id_md_use  (decode -> hazard controller)
//           stall, forward_rs_src, forward_rt_src, md_start, md_busy
//           (hazard controller -> pipeline)
// Modports: master = decode/pipeline side, slave = hazard controller.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  reg_idx_t   id_rs;
  reg_idx_t   id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  reg_idx_t   id_dst;
  logic       id_wr;
  logic       id_load;
  logic       id_md;
  logic       id_md_div;
  logic       id_md_use;
  logic       stall;
  logic [1:0] forward_rs_src;
  logic [1:0] forward_rt_src;
  logic       md_start;
  logic       md_busy;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_wr, id_load,
           id_md, id_md_div, id_md_use,
    input  stall, forward_rs_src, forward_rt_src, md_start, md_busy
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_wr, id_load,
           id_md, id_md_div, id_md_use,
    output stall, forward_rs_src, forward_rt_src, md_start, md_busy
  );

endinterface

// File: rtl/hazard_ctrl_md_busy_counter.sv
// rtl/hazard_ctrl_md_busy_counter.sv - HI/LO unit busy countdown
//
// Purpose : loads MULT_CYCLES/DIV_CYCLES when a mult/div is in EX, then
//           counts down to 0; busy while non-zero.
// Ports   : i_clk, i_reset (sync, active-high), i_start (mult/div in EX),
//           i_div (1 = div), o_busy (count != 0).
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_div,
  output logic o_busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= i_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_busy = (r_count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - five-stage pipeline hazard controller (forwarding, stalls, mult/div busy)
//
// Purpose : keeps a shadow of the EX/MEM/WB instructions and derives the EX
//           forwarding selects, the load-use / mult-div stall and the HI/LO
//           busy countdown.
// Ports   : clk, reset (sync, active-high), bus (hazard_ctrl_if.slave).
// Params  : MULT_CYCLES, DIV_CYCLES - busy cycles after a mult/div enters EX.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  ex_stage_t r_ex;
  reg_idx_t  r_mem_dst;
  logic      r_mem_wr;
  logic      r_mem_load;
  reg_idx_t  r_wb_dst;
  logic      r_wb_wr;

  ex_stage_t w_id;
  logic      w_ex_wr_eff;
  logic      w_stall_lu;
  logic      w_stall_md;
  logic      w_stall;
  logic      w_md_busy;

  // A destination of $0 is folded into wr=0 at ID so that nothing downstream
  // ever matches against it.
  always_comb begin
    w_id        = '0;
    w_id.rs     = bus.id_rs;
    w_id.rt     = bus.id_rt;
    w_id.dst    = bus.id_dst;
    w_id.wr     = bus.id_wr && (bus.id_dst != 5'd0);
    w_id.load   = bus.id_load;
    w_id.md     = bus.id_md;
    w_id.md_div = bus.id_md_div;
  end

  assign w_ex_wr_eff = r_ex.wr && (r_ex.dst != 5'd0);

  assign w_stall_lu = r_ex.load && w_ex_wr_eff &&
                      ((bus.id_use_rs && (bus.id_rs == r_ex.dst)) ||
                       (bus.id_use_rt && (bus.id_rt == r_ex.dst)));

  assign w_stall_md = (bus.id_md || bus.id_md_use) && (w_md_busy || r_ex.md);

  assign w_stall = w_stall_lu || w_stall_md;

  // While stalling, ID holds and EX takes a bubble; MEM and WB keep draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex       <= '0;
      r_mem_dst  <= '0;
      r_mem_wr   <= 1'b0;
      r_mem_load <= 1'b0;
      r_wb_dst   <= '0;
      r_wb_wr    <= 1'b0;
    end else begin
      r_ex       <= w_stall ? '0 : w_id;
      r_mem_dst  <= r_ex.dst;
      r_mem_wr   <= w_ex_wr_eff;
      r_mem_load <= r_ex.load;
      r_wb_dst   <= r_mem_dst;
      r_wb_wr    <= r_mem_wr;
    end
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (r_ex.md),
    .i_div   (r_ex.md_div),
    .o_busy  (w_md_busy)
  );

  assign bus.stall          = w_stall;
  assign bus.forward_rs_src = fwd_sel(r_ex.rs, r_mem_dst, r_mem_wr, r_mem_load, r_wb_dst, r_wb_wr);
  assign bus.forward_rt_src = fwd_sel(r_ex.rt, r_mem_dst, r_mem_wr, r_mem_load, r_wb_dst, r_wb_wr);
  assign bus.md_start       = r_ex.md;
  assign bus.md_busy        = w_md_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  hazard_ctrl_if bus_if ();

  hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                        input logic use_rs, input logic use_rt,
                        input logic [4:0] dst, input logic wr, input logic load,
                        input logic md, input logic md_div, input logic md_use);
    bus_if.id_rs     = rs;
    bus_if.id_rt     = rt;
    bus_if.id_use_rs = use_rs;
    bus_if.id_use_rt = use_rt;
    bus_if.id_dst    = dst;
    bus_if.id_wr     = wr;
    bus_if.id_load   = load;
    bus_if.id_md     = md;
    bus_if.id_md_div = md_div;
    bus_if.id_md_use = md_use;
    #1;
  endtask

  task automatic nop();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nop();
    step();
    reset = 1'b0;
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    // lw $8 with a mflo-like flag set: state is clear, so nothing may fire
    set_id(5'd8, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    step();
    chk("reset_stall",  {1'b0, bus_if.stall}, 2'd0);
    chk("reset_fwd_rs", bus_if.forward_rs_src, 2'd0);
    chk("reset_fwd_rt", bus_if.forward_rt_src, 2'd0);
    chk("reset_md_start", {1'b0, bus_if.md_start}, 2'd0);
    chk("reset_md_busy",  {1'b0, bus_if.md_busy}, 2'd0);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // addu $8,$1,$2
    chk("b2b_stall0", {1'b0, bus_if.stall}, 2'd0);
    step();
    set_id(5'd8, 5'd3, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // subu $9,$8,$3
    chk("b2b_stall1", {1'b0, bus_if.stall}, 2'd0);
    chk("b2b_fwd_rs_addu_ex", bus_if.forward_rs_src, 2'd0);
    step();
    nop();
    chk("b2b_fwd_rs", bus_if.forward_rs_src, 2'd1);
    chk("b2b_fwd_rt", bus_if.forward_rt_src, 2'd0);
    chk("b2b_stall2", {1'b0, bus_if.stall}, 2'd0);
  endtask

  task automatic test_distance2();
    do_reset();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // addu $8
    step();
    nop();
    step();
    set_id(5'd4, 5'd8, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // or $10,$4,$8
    step();
    nop();
    chk("d2_fwd_rt", bus_if.forward_rt_src, 2'd2);
    chk("d2_fwd_rs", bus_if.forward_rs_src, 2'd0);
  endtask

  task automatic test_priority();
    do_reset();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // addu $8,$1,$2
    step();
    set_id(5'd3, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // addu $8,$3,$4
    step();
    set_id(5'd8, 5'd8, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // addu $11,$8,$8
    step();
    nop();
    chk("prio_fwd_rs", bus_if.forward_rs_src, 2'd1);
    chk("prio_fwd_rt", bus_if.forward_rt_src, 2'd1);
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // lw $8,0($1)
    chk("lu_no_stall_lw", {1'b0, bus_if.stall}, 2'd0);
    step();
    set_id(5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // addu $9,$8,$8
    chk("lu_stall", {1'b0, bus_if.stall}, 2'd1);
    step();
    chk("lu_stall_one_cycle", {1'b0, bus_if.stall}, 2'd0);
    chk("lu_bubble_fwd_rs", bus_if.forward_rs_src, 2'd0);
    step();
    nop();
    chk("lu_fwd_rs", bus_if.forward_rs_src, 2'd2);
    chk("lu_fwd_rt", bus_if.forward_rt_src, 2'd2);
    chk("lu_no_more_stall", {1'b0, bus_if.stall}, 2'd0);
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // lw $0,0($1)
    step();
    set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // addu $9,$0,$0
    chk("zero_stall", {1'b0, bus_if.stall}, 2'd0);
    step();
    nop();
    chk("zero_fwd_rs", bus_if.forward_rs_src, 2'd0);
    chk("zero_fwd_rt", bus_if.forward_rt_src, 2'd0);
  endtask

  task automatic test_div_mflo();
    int stalls;
    bit done;
    do_reset();
    set_id(5'd4, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); // div $4,$5
    chk("div_no_stall", {1'b0, bus_if.stall}, 2'd0);
    step();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); // mflo $8
    chk("div_md_start", {1'b0, bus_if.md_start}, 2'd1);
    chk("div_busy_not_yet", {1'b0, bus_if.md_busy}, 2'd0);
    stalls = 0;
    done   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!done) begin
        if (bus_if.stall) begin
          stalls++;
          if (stalls == 2) chk("div_busy_after_load", {1'b0, bus_if.md_busy}, 2'd1);
          if (stalls == 11) chk("div_busy_last_stall", {1'b0, bus_if.md_busy}, 2'd1);
          step();
        end else begin
          done = 1'b1;
        end
      end
    end
    chk("div_loop_bound", {1'b0, done}, 2'd1);
    n_checks++;
    if (stalls != 11) begin
      n_fail++;
      $display("FAIL div_stall_cycles: got %0d expected 11", stalls);
    end
    chk("div_busy_released", {1'b0, bus_if.md_busy}, 2'd0);
  endtask

  task automatic test_mult_indep();
    int busy_cycles;
    do_reset();
    set_id(5'd4, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // mult $4,$5
    step();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // addu $9,$1,$2
    chk("mult_addu_no_stall", {1'b0, bus_if.stall}, 2'd0);
    chk("mult_md_start", {1'b0, bus_if.md_start}, 2'd1);
    step();
    nop();
    busy_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_if.md_busy) busy_cycles++;
      step();
    end
    n_checks++;
    if (busy_cycles != 5) begin
      n_fail++;
      $display("FAIL mult_busy_cycles: got %0d expected 5", busy_cycles);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_id(5'd4, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); // div
    step();
    nop();
    step();
    step();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1); // mflo $8
    chk("rmid_busy_before", {1'b0, bus_if.md_busy}, 2'd1);
    chk("rmid_stall_before", {1'b0, bus_if.stall}, 2'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rmid_busy", {1'b0, bus_if.md_busy}, 2'd0);
    chk("rmid_stall", {1'b0, bus_if.stall}, 2'd0);
    chk("rmid_fwd_rs", bus_if.forward_rs_src, 2'd0);
    chk("rmid_fwd_rt", bus_if.forward_rt_src, 2'd0);
    chk("rmid_md_start", {1'b0, bus_if.md_start}, 2'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    nop();
    test_reset();
    test_back_to_back();
    test_distance2();
    test_priority();
    test_load_use();
    test_zero_reg();
    test_div_mflo();
    test_mult_indep();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
